// File: rtl/csr_bank.sv
// Machine-mode CSR register file: combinational read/illegal decode, WRITE/SET/CLEAR updates,
// 64-bit cycle/instret counters, trap entry / mret sequencing and current privilege level.
package csr_bank_pkg;
  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csrOperation_e;

  typedef enum logic [1:0] {
    PRIV_U    = 2'b00,
    PRIV_S    = 2'b01,
    PRIV_RSVD = 2'b10,
    PRIV_M    = 2'b11
  } privilegeLevel_e;
endpackage

module csr_bank
  import csr_bank_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] HART_ID     = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            read_enable_i,
  input  logic            write_enable_i,
  input  csrOperation_e   operation_i,
  input  logic [11:0]     address_i,
  input  logic [31:0]     data_i,
  output logic [31:0]     data_o,
  output logic            illegal_o,
  input  logic            instret_i,
  input  logic            exception_i,
  input  logic [31:0]     exception_pc_i,
  input  logic [31:0]     exception_code_i,
  input  logic [31:0]     exception_tval_i,
  input  logic            mret_i,
  input  logic [2:0]      irq_i,
  output privilegeLevel_e privilege_o,
  output logic [31:0]     mtvec_o,
  output logic [31:0]     mepc_o,
  output logic            interrupt_pending_o
);

  localparam logic [31:0] MIE_MASK   = 32'h0000_0888;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  privilegeLevel_e privilege_q, privilege_d;
  privilegeLevel_e mstatusMpp_q, mstatusMpp_d;
  logic            mstatusMie_q, mstatusMie_d;
  logic            mstatusMpie_q, mstatusMpie_d;
  logic [31:0]     mieReg_q, mieReg_d;
  logic [31:0]     mtvec_q, mtvec_d;
  logic [31:0]     mscratch_q, mscratch_d;
  logic [31:0]     mepc_q, mepc_d;
  logic [31:0]     mcause_q, mcause_d;
  logic [31:0]     mtval_q, mtval_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  logic [31:0] mstatusValue;
  logic [31:0] mipValue;
  logic [31:0] readValue;
  logic [31:0] writeValue;
  logic        implemented;
  logic        writeEnable;

  assign mstatusValue = {19'b0, mstatusMpp_q, 3'b0, mstatusMpie_q, 3'b0, mstatusMie_q, 3'b0};
  assign mipValue     = {20'b0, irq_i[2], 3'b0, irq_i[1], 3'b0, irq_i[0], 3'b0};

  always_comb begin
    implemented = 1'b1;
    readValue   = '0;
    case (address_i)
      12'h300:          readValue = mstatusValue;
      12'h301:          readValue = MISA_VALUE;
      12'h304:          readValue = mieReg_q;
      12'h305:          readValue = mtvec_q;
      12'h340:          readValue = mscratch_q;
      12'h341:          readValue = mepc_q;
      12'h342:          readValue = mcause_q;
      12'h343:          readValue = mtval_q;
      12'h344:          readValue = mipValue;
      12'hB00, 12'hC00: readValue = mcycle_q[31:0];
      12'hB80, 12'hC80: readValue = mcycle_q[63:32];
      12'hB02, 12'hC02: readValue = minstret_q[31:0];
      12'hB82, 12'hC82: readValue = minstret_q[63:32];
      12'hF14:          readValue = HART_ID;
      default:          implemented = 1'b0;
    endcase
  end

  assign data_o    = (read_enable_i && implemented) ? readValue : '0;
  assign illegal_o = (read_enable_i || write_enable_i) && !implemented;

  // A trap in the same cycle swallows any CSR write.
  assign writeEnable = write_enable_i && (operation_i != CSR_NONE) && implemented && !exception_i;

  always_comb begin
    case (operation_i)
      CSR_WRITE: writeValue = data_i;
      CSR_SET:   writeValue = readValue | data_i;
      CSR_CLEAR: writeValue = readValue & ~data_i;
      default:   writeValue = readValue;
    endcase
  end

  always_comb begin
    privilege_d   = privilege_q;
    mstatusMpp_d  = mstatusMpp_q;
    mstatusMie_d  = mstatusMie_q;
    mstatusMpie_d = mstatusMpie_q;
    mieReg_d      = mieReg_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    mcycle_d      = mcycle_q + 64'd1;
    minstret_d    = instret_i ? minstret_q + 64'd1 : minstret_q;

    if (writeEnable) begin
      case (address_i)
        12'h300: begin
          mstatusMie_d  = writeValue[3];
          mstatusMpie_d = writeValue[7];
          mstatusMpp_d  = privilegeLevel_e'(writeValue[12:11]);
        end
        12'h304: mieReg_d   = writeValue & MIE_MASK;
        12'h305: mtvec_d    = writeValue & ALIGN_MASK;
        12'h340: mscratch_d = writeValue;
        12'h341: mepc_d     = writeValue & ALIGN_MASK;
        12'h342: mcause_d   = writeValue;
        12'h343: mtval_d    = writeValue;
        12'hB00: mcycle_d   = {mcycle_q[63:32], writeValue};
        12'hB80: mcycle_d   = {writeValue, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], writeValue};
        12'hB82: minstret_d = {writeValue, minstret_q[31:0]};
        default: ;
      endcase
    end

    // Trap beats mret; either one overrides a same-cycle mstatus write.
    if (exception_i) begin
      mepc_d        = exception_pc_i & ALIGN_MASK;
      mcause_d      = exception_code_i;
      mtval_d       = exception_tval_i;
      mstatusMpie_d = mstatusMie_q;
      mstatusMie_d  = 1'b0;
      mstatusMpp_d  = privilege_q;
      privilege_d   = PRIV_M;
    end else if (mret_i) begin
      mstatusMie_d  = mstatusMpie_q;
      mstatusMpie_d = 1'b1;
      privilege_d   = mstatusMpp_q;
      mstatusMpp_d  = PRIV_U;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      privilege_q   <= PRIV_M;
      mstatusMpp_q  <= PRIV_U;
      mstatusMie_q  <= 1'b0;
      mstatusMpie_q <= 1'b0;
      mieReg_q      <= '0;
      mtvec_q       <= MTVEC_RESET & ALIGN_MASK;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      mcycle_q      <= '0;
      minstret_q    <= '0;
    end else begin
      privilege_q   <= privilege_d;
      mstatusMpp_q  <= mstatusMpp_d;
      mstatusMie_q  <= mstatusMie_d;
      mstatusMpie_q <= mstatusMpie_d;
      mieReg_q      <= mieReg_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
    end
  end

  assign privilege_o         = privilege_q;
  assign mtvec_o             = mtvec_q;
  assign mepc_o              = mepc_q;
  assign interrupt_pending_o = mstatusMie_q && |(mieReg_q & mipValue);

endmodule

// File: tb/tb_csr_bank.sv
// Directed bench for csr_bank: stimulus pushes expected read responses into a scoreboard queue,
// a negedge monitor pops one entry for every cycle the DUT presents read data.
module tb_csr_bank;
  import csr_bank_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            readEnable;
  logic            writeEnable;
  csrOperation_e   operation;
  logic [11:0]     address;
  logic [31:0]     dataIn;
  logic [31:0]     dataOut;
  logic            illegal;
  logic            instret;
  logic            exception;
  logic [31:0]     exceptionPc;
  logic [31:0]     exceptionCode;
  logic [31:0]     exceptionTval;
  logic            mret;
  logic [2:0]      irq;
  privilegeLevel_e privilege;
  logic [31:0]     mtvec;
  logic [31:0]     mepc;
  logic            interruptPending;

  typedef struct {
    string           name;
    logic [31:0]     data;
    logic            illegal;
    logic            side;
    privilegeLevel_e priv;
    logic            pend;
    logic [31:0]     mepc;
    logic [31:0]     mtvec;
  } expect_t;

  expect_t scoreboard[$];
  expect_t monItem;
  int testsRun    = 0;
  int testsFailed = 0;

  csr_bank dut (
    .clk                 (clk),
    .reset               (reset),
    .read_enable_i       (readEnable),
    .write_enable_i      (writeEnable),
    .operation_i         (operation),
    .address_i           (address),
    .data_i              (dataIn),
    .data_o              (dataOut),
    .illegal_o           (illegal),
    .instret_i           (instret),
    .exception_i         (exception),
    .exception_pc_i      (exceptionPc),
    .exception_code_i    (exceptionCode),
    .exception_tval_i    (exceptionTval),
    .mret_i              (mret),
    .irq_i               (irq),
    .privilege_o         (privilege),
    .mtvec_o             (mtvec),
    .mepc_o              (mepc),
    .interrupt_pending_o (interruptPending)
  );

  always #5 clk = ~clk;

  function automatic void compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endfunction

  task automatic checkOutput(input expect_t e);
    compare({e.name, ".data"}, dataOut, e.data);
    compare({e.name, ".illegal"}, {31'b0, illegal}, {31'b0, e.illegal});
    if (e.side) begin
      compare({e.name, ".priv"}, {30'b0, privilege}, {30'b0, e.priv});
      compare({e.name, ".pend"}, {31'b0, interruptPending}, {31'b0, e.pend});
      compare({e.name, ".mepc_o"}, mepc, e.mepc);
      compare({e.name, ".mtvec_o"}, mtvec, e.mtvec);
    end
  endtask

  always @(negedge clk) begin
    if (readEnable) begin
      if (scoreboard.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_read: got data %h, expected no read", dataOut);
      end else begin
        monItem = scoreboard.pop_front();
        checkOutput(monItem);
      end
    end
  end

  task automatic expectRead(input string name, input logic [31:0] data, input logic ill);
    expect_t e;
    e.name = name; e.data = data; e.illegal = ill; e.side = 1'b0;
    e.priv = PRIV_M; e.pend = 1'b0; e.mepc = '0; e.mtvec = '0;
    scoreboard.push_back(e);
  endtask

  task automatic expectSide(input string name, input logic [31:0] data, input privilegeLevel_e priv,
                            input logic pend, input logic [31:0] mepcExp, input logic [31:0] mtvecExp);
    expect_t e;
    e.name = name; e.data = data; e.illegal = 1'b0; e.side = 1'b1;
    e.priv = priv; e.pend = pend; e.mepc = mepcExp; e.mtvec = mtvecExp;
    scoreboard.push_back(e);
  endtask

  // One call per clock: inputs change 1 time unit after the rising edge; trap/mret are one-shot.
  task automatic applyStimulus(input logic re, input logic we, input csrOperation_e op,
                               input logic [11:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    readEnable  = re;
    writeEnable = we;
    operation   = op;
    address     = addr;
    dataIn      = data;
    exception   = 1'b0;
    mret        = 1'b0;
  endtask

  task automatic raiseTrap(input logic [31:0] pc, input logic [31:0] code, input logic [31:0] tval);
    exception     = 1'b1;
    exceptionPc   = pc;
    exceptionCode = code;
    exceptionTval = tval;
  endtask

  initial begin
    reset = 1'b1; readEnable = 1'b0; writeEnable = 1'b0; operation = CSR_NONE;
    address = '0; dataIn = '0; instret = 1'b0; exception = 1'b0; exceptionPc = '0;
    exceptionCode = '0; exceptionTval = '0; mret = 1'b0; irq = 3'b000;

    #1;
    readEnable = 1'b1; address = 12'h340;
    expectSide("in_reset_mscratch", 32'h0, PRIV_M, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; address = 12'h300; instret = 1'b1;
    expectSide("reset_mstatus", 32'h0, PRIV_M, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 0, CSR_NONE, 12'h305, 0); expectRead("reset_mtvec", 32'h0, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'h301, 0); expectRead("misa", 32'h4000_0100, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'hF14, 0); expectRead("mhartid", 32'h0, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'h342, 0); expectRead("reset_mcause", 32'h0, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'hB02, 0); instret = 1'b0;
    expectRead("minstret_5", 32'd5, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'hC82, 0); expectRead("instreth", 32'h0, 1'b0);

    applyStimulus(0, 1, CSR_WRITE, 12'h340, 32'hDEAD_BEEF);
    applyStimulus(1, 1, CSR_SET,   12'h340, 32'h0000_00F0); expectRead("mscratch_write", 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1, 1, CSR_CLEAR, 12'h340, 32'h0000_000F); expectRead("mscratch_set", 32'hDEAD_BEFF, 1'b0);
    applyStimulus(1, 0, CSR_NONE,  12'h340, 0);             expectRead("mscratch_clear", 32'hDEAD_BEF0, 1'b0);
    applyStimulus(0, 1, CSR_WRITE, 12'h305, 32'h8000_0003);
    applyStimulus(1, 0, CSR_NONE,  12'h305, 0);
    expectSide("mtvec_align", 32'h8000_0000, PRIV_M, 1'b0, 32'h0, 32'h8000_0000);

    applyStimulus(0, 1, CSR_WRITE, 12'hB00, 32'hFFFF_FFFE);
    applyStimulus(0, 1, CSR_WRITE, 12'hB80, 32'h0000_0001);
    applyStimulus(0, 0, CSR_NONE, 12'h000, 0);
    applyStimulus(0, 0, CSR_NONE, 12'h000, 0);
    applyStimulus(1, 0, CSR_NONE, 12'hB00, 0); expectRead("mcycle_wrap", 32'h0, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'hB80, 0); expectRead("mcycleh_carry", 32'h2, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'hC80, 0); expectRead("cycleh_mirror", 32'h2, 1'b0);

    applyStimulus(1, 0, CSR_NONE,  12'h7C0, 0);            expectRead("illegal_read", 32'h0, 1'b1);
    applyStimulus(1, 1, CSR_WRITE, 12'h301, 32'hFFFF_FFFF); expectRead("misa_ro_write", 32'h4000_0100, 1'b0);
    applyStimulus(1, 1, CSR_SET,   12'h7C0, 32'hFFFF_FFFF); expectRead("illegal_write", 32'h0, 1'b1);
    applyStimulus(1, 0, CSR_NONE,  12'h301, 0);            expectRead("misa_after", 32'h4000_0100, 1'b0);

    applyStimulus(0, 1, CSR_WRITE, 12'h300, 32'h8);
    applyStimulus(1, 1, CSR_WRITE, 12'h340, 32'h1234_5678);
    raiseTrap(32'h0000_0106, 32'h2, 32'h55);
    expectRead("trap_cycle_mscratch", 32'hDEAD_BEF0, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'h341, 0);
    expectSide("trap_mepc", 32'h104, PRIV_M, 1'b0, 32'h104, 32'h8000_0000);
    applyStimulus(1, 0, CSR_NONE, 12'h342, 0); expectRead("trap_mcause", 32'h2, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'h343, 0); expectRead("trap_mtval", 32'h55, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'h300, 0); expectRead("trap_mstatus", 32'h1880, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'h340, 0); expectRead("trap_dropped_write", 32'hDEAD_BEF0, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'h300, 0); mret = 1'b1;
    expectRead("mret_cycle", 32'h1880, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'h300, 0);
    expectSide("mret_to_m", 32'h88, PRIV_M, 1'b0, 32'h104, 32'h8000_0000);
    applyStimulus(1, 0, CSR_NONE, 12'h300, 0); mret = 1'b1;
    expectRead("mret2_cycle", 32'h88, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'h300, 0);
    expectSide("mret_to_u", 32'h88, PRIV_U, 1'b0, 32'h104, 32'h8000_0000);
    applyStimulus(0, 0, CSR_NONE, 12'h000, 0);
    raiseTrap(32'h0000_0203, 32'h8000_0007, 32'h0); mret = 1'b1;
    applyStimulus(1, 0, CSR_NONE, 12'h300, 0);
    expectSide("trap_beats_mret", 32'h80, PRIV_M, 1'b0, 32'h200, 32'h8000_0000);
    applyStimulus(1, 0, CSR_NONE, 12'h342, 0); expectRead("trap2_mcause", 32'h8000_0007, 1'b0);

    applyStimulus(0, 1, CSR_WRITE, 12'h304, 32'hFFFF_FFFF);
    applyStimulus(1, 1, CSR_WRITE, 12'h304, 32'h0000_0080); expectRead("mie_mask", 32'h888, 1'b0);
    applyStimulus(0, 1, CSR_WRITE, 12'h300, 32'h8); irq = 3'b010;
    applyStimulus(1, 0, CSR_NONE, 12'h344, 0);
    expectSide("mip_pending", 32'h80, PRIV_M, 1'b1, 32'h200, 32'h8000_0000);
    applyStimulus(1, 1, CSR_CLEAR, 12'h300, 32'h8);
    expectSide("clear_cycle", 32'h8, PRIV_M, 1'b1, 32'h200, 32'h8000_0000);
    applyStimulus(1, 0, CSR_NONE, 12'h300, 0);
    expectSide("clear_mie", 32'h0, PRIV_M, 1'b0, 32'h200, 32'h8000_0000);

    applyStimulus(0, 1, CSR_SET, 12'h300, 32'h8);
    applyStimulus(1, 1, CSR_SET, 12'h304, 32'h8);
    raiseTrap(32'h0000_0400, 32'h3, 32'h0);
    #2 reset = 1'b1;
    expectSide("async_reset", 32'h0, PRIV_M, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 0, CSR_NONE, 12'h340, 0); expectRead("reset_hold_mscratch", 32'h0, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'h300, 0); reset = 1'b0;
    expectSide("post_reset_mstatus", 32'h0, PRIV_M, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 0, CSR_NONE, 12'h342, 0); expectRead("post_reset_mcause", 32'h0, 1'b0);
    applyStimulus(1, 0, CSR_NONE, 12'h304, 0); expectRead("post_reset_mie", 32'h0, 1'b0);
    applyStimulus(0, 0, CSR_NONE, 12'h000, 0);
    @(posedge clk);
    #1;

    compare("scoreboard_drained", scoreboard.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
